// File: rtl/id_ex_hazard_stage_pkg.sv
// Shared definitions for the ID/EX stage: ALU operation classes, default
// datapath widths and the packed layout of the decoded control bundle.
package id_ex_hazard_stage_pkg;

    localparam int MIPS_DATA_W = 32;
    localparam int MIPS_REG_AW = 5;

    // ALU control class carried from decode to the ALU control unit
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluOp_e;

    // Control bundle, field order fixed MSB to LSB
    typedef struct packed {
        logic   regWrite;
        logic   memRead;
        logic   memWrite;
        logic   memtoReg;
        logic   aluSrc;
        logic   regDst;
        aluOp_e aluOp;
    } ctrl_t;

    // All-zero controls: a bubble that writes nothing and touches no memory
    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_hazard_stage_if.sv
// ID -> EX bus: decoded fields from the ID stage and their registered copies
// presented to the EX stage and its forwarding unit.
interface id_ex_hazard_stage_if
    import id_ex_hazard_stage_pkg::*;
#(
    parameter int DATA_W = MIPS_DATA_W,
    parameter int REG_AW = MIPS_REG_AW
) ();

    // Decode side
    logic              ID_RegWrite;
    logic              ID_MemRead;
    logic              ID_MemWrite;
    logic              ID_MemtoReg;
    logic              ID_ALUSrc;
    logic              ID_RegDst;
    logic [1:0]        ID_ALUOp;
    logic              ID_UsesRt;
    logic [DATA_W-1:0] ID_ReadData1;
    logic [DATA_W-1:0] ID_ReadData2;
    logic [DATA_W-1:0] ID_Imm;
    logic [REG_AW-1:0] ID_rs;
    logic [REG_AW-1:0] ID_rt;
    logic [REG_AW-1:0] ID_rd;

    // Execute side
    logic              EX_RegWrite;
    logic              EX_MemRead;
    logic              EX_MemWrite;
    logic              EX_MemtoReg;
    logic              EX_ALUSrc;
    logic              EX_RegDst;
    logic [1:0]        EX_ALUOp;
    logic [DATA_W-1:0] EX_ReadData1;
    logic [DATA_W-1:0] EX_ReadData2;
    logic [DATA_W-1:0] EX_Imm;
    logic [REG_AW-1:0] EX_rs;
    logic [REG_AW-1:0] EX_rt;
    logic [REG_AW-1:0] EX_rd;

    // Decoder drives ID fields and observes the EX copies
    modport master (
        output ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc,
               ID_RegDst, ID_ALUOp, ID_UsesRt, ID_ReadData1, ID_ReadData2,
               ID_Imm, ID_rs, ID_rt, ID_rd,
        input  EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemtoReg, EX_ALUSrc,
               EX_RegDst, EX_ALUOp, EX_ReadData1, EX_ReadData2, EX_Imm,
               EX_rs, EX_rt, EX_rd
    );

    // Pipeline register consumes ID fields and produces the EX copies
    modport slave (
        input  ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc,
               ID_RegDst, ID_ALUOp, ID_UsesRt, ID_ReadData1, ID_ReadData2,
               ID_Imm, ID_rs, ID_rt, ID_rd,
        output EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemtoReg, EX_ALUSrc,
               EX_RegDst, EX_ALUOp, EX_ReadData1, EX_ReadData2, EX_Imm,
               EX_rs, EX_rt, EX_rd
    );

endinterface

// File: rtl/id_ex_hazard_stage_load_use_detect.sv
// Load-use hazard detector: flags a consumer in ID whose source register is
// the destination of a load currently in the next stage. $zero never hazards.
module load_use_detect #(
    parameter int REG_AW = 5
) (
    input  logic              exMemRead,
    input  logic [REG_AW-1:0] exRt,
    input  logic [REG_AW-1:0] idRs,
    input  logic [REG_AW-1:0] idRt,
    input  logic              idUsesRt,
    output logic              loadUseHazard
);

    logic rsMatch;
    logic rtMatch;

    // rt only counts as a source when the instruction actually reads it
    always_comb begin
        rsMatch       = (exRt == idRs);
        rtMatch       = idUsesRt && (exRt == idRt);
        loadUseHazard = exMemRead && (exRt != '0) && (rsMatch || rtMatch);
    end

endmodule

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush,
// global hold, PC/IF-ID stall enables and saturating event counters.
module id_ex_hazard_stage
    import id_ex_hazard_stage_pkg::*;
#(
    parameter int DATA_W = MIPS_DATA_W,
    parameter int REG_AW = MIPS_REG_AW,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    id_ex_hazard_stage_if.slave bus,
    input  logic             BranchFlush,
    input  logic             Hold,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    ctrl_t             idCtrl;
    ctrl_t             exCtrl;
    logic [DATA_W-1:0] exReadData1;
    logic [DATA_W-1:0] exReadData2;
    logic [DATA_W-1:0] exImm;
    logic [REG_AW-1:0] exRs;
    logic [REG_AW-1:0] exRt;
    logic [REG_AW-1:0] exRd;
    logic              loadUseHazard;
    logic              killCtrl;

    // Pack the decoded controls into the shared bundle layout
    always_comb begin
        idCtrl          = CTRL_BUBBLE;
        idCtrl.regWrite = bus.ID_RegWrite;
        idCtrl.memRead  = bus.ID_MemRead;
        idCtrl.memWrite = bus.ID_MemWrite;
        idCtrl.memtoReg = bus.ID_MemtoReg;
        idCtrl.aluSrc   = bus.ID_ALUSrc;
        idCtrl.regDst   = bus.ID_RegDst;
        idCtrl.aluOp    = aluOp_e'(bus.ID_ALUOp);
    end

    load_use_detect #(
        .REG_AW(REG_AW)
    ) u_load_use_detect (
        .exMemRead    (exCtrl.memRead),
        .exRt         (exRt),
        .idRs         (bus.ID_rs),
        .idRt         (bus.ID_rt),
        .idUsesRt     (bus.ID_UsesRt),
        .loadUseHazard(loadUseHazard)
    );

    // Front-end stall: a hazard or a global hold both freeze PC and IF/ID.
    // A flush coinciding with a hazard still stalls; the branch unit
    // redirects the PC on the following cycle.
    always_comb begin
        PCWrite     = ~(loadUseHazard | Hold);
        IF_ID_Write = ~(loadUseHazard | Hold);
        killCtrl    = BranchFlush | loadUseHazard;
    end

    // ID/EX register: hold freezes, flush or hazard zeroes the controls,
    // data and address fields always follow ID when not held
    always_ff @(posedge clk) begin
        // NOTE: data/address fields are reset as well, not only the controls,
        // so every EX output reads zero straight out of reset.
        if (!reset_n) begin
            exCtrl      <= CTRL_BUBBLE;
            exReadData1 <= '0;
            exReadData2 <= '0;
            exImm       <= '0;
            exRs        <= '0;
            exRt        <= '0;
            exRd        <= '0;
        end else if (!Hold) begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge state, so the hazard uses the old exRt/memRead.
            exCtrl      <= killCtrl ? CTRL_BUBBLE : idCtrl;
            exReadData1 <= bus.ID_ReadData1;
            exReadData2 <= bus.ID_ReadData2;
            exImm       <= bus.ID_Imm;
            exRs        <= bus.ID_rs;
            exRt        <= bus.ID_rt;
            exRd        <= bus.ID_rd;
        end
    end

    // Saturating event counters; a flush masks a simultaneous hazard
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else if (!Hold) begin
            if (BranchFlush) begin
                if (FlushCount != '1) FlushCount <= FlushCount + CNT_W'(1);
            end else if (loadUseHazard) begin
                if (StallCount != '1) StallCount <= StallCount + CNT_W'(1);
            end
        end
    end

    // Drive the EX side of the bus from the stage registers
    always_comb begin
        bus.EX_RegWrite  = exCtrl.regWrite;
        bus.EX_MemRead   = exCtrl.memRead;
        bus.EX_MemWrite  = exCtrl.memWrite;
        bus.EX_MemtoReg  = exCtrl.memtoReg;
        bus.EX_ALUSrc    = exCtrl.aluSrc;
        bus.EX_RegDst    = exCtrl.regDst;
        bus.EX_ALUOp     = exCtrl.aluOp;
        bus.EX_ReadData1 = exReadData1;
        bus.EX_ReadData2 = exReadData2;
        bus.EX_Imm       = exImm;
        bus.EX_rs        = exRs;
        bus.EX_rt        = exRt;
        bus.EX_rd        = exRd;
    end

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Self-checking bench for id_ex_hazard_stage: table-driven pipeline vectors
// plus hand-written reset sequences. A second instance with CNT_W=2 sees the
// same stimulus to exercise counter saturation.
module tb_id_ex_hazard_stage;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       BranchFlush;
    logic       Hold;
    logic       PCWrite, IF_ID_Write;
    logic [15:0] StallCount, FlushCount;
    logic       smallPCWrite, smallIF_ID_Write;
    logic [1:0] smallStallCount, smallFlushCount;

    int testsRun = 0;
    int testsFailed = 0;

    id_ex_hazard_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();
    id_ex_hazard_stage_if #(.DATA_W(32), .REG_AW(5)) busSmall ();

    id_ex_hazard_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .BranchFlush(BranchFlush),
        .Hold       (Hold),
        .PCWrite    (PCWrite),
        .IF_ID_Write(IF_ID_Write),
        .StallCount (StallCount),
        .FlushCount (FlushCount)
    );

    id_ex_hazard_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(2)) dutSmall (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (busSmall),
        .BranchFlush(BranchFlush),
        .Hold       (Hold),
        .PCWrite    (smallPCWrite),
        .IF_ID_Write(smallIF_ID_Write),
        .StallCount (smallStallCount),
        .FlushCount (smallFlushCount)
    );

    // Both instances see identical decode-side stimulus
    assign busSmall.ID_RegWrite  = bus.ID_RegWrite;
    assign busSmall.ID_MemRead   = bus.ID_MemRead;
    assign busSmall.ID_MemWrite  = bus.ID_MemWrite;
    assign busSmall.ID_MemtoReg  = bus.ID_MemtoReg;
    assign busSmall.ID_ALUSrc    = bus.ID_ALUSrc;
    assign busSmall.ID_RegDst    = bus.ID_RegDst;
    assign busSmall.ID_ALUOp     = bus.ID_ALUOp;
    assign busSmall.ID_UsesRt    = bus.ID_UsesRt;
    assign busSmall.ID_ReadData1 = bus.ID_ReadData1;
    assign busSmall.ID_ReadData2 = bus.ID_ReadData2;
    assign busSmall.ID_Imm       = bus.ID_Imm;
    assign busSmall.ID_rs        = bus.ID_rs;
    assign busSmall.ID_rt        = bus.ID_rt;
    assign busSmall.ID_rd        = bus.ID_rd;

    always #5 clk = ~clk;

    typedef struct {
        logic        rw, mr, ur;
        logic [1:0]  alu;
        logic [4:0]  rs, rt;
        logic        fl, hd;
        logic [31:0] data;
        logic        ePc;
        logic        eRw, eMr;
        logic [1:0]  eAlu;
        logic [4:0]  eRs, eRt;
        logic [31:0] eData;
        int          eSc, eFc;
    } vec_t;

    localparam int NVEC = 28;
    vec_t vecs[NVEC];

    function automatic vec_t mk(logic rw, logic mr, logic ur, logic [1:0] alu,
                                logic [4:0] rs, logic [4:0] rt, logic fl, logic hd,
                                logic [31:0] data, logic ePc, logic eRw, logic eMr,
                                logic [1:0] eAlu, logic [4:0] eRs, logic [4:0] eRt,
                                logic [31:0] eData, int eSc, int eFc);
        vec_t v;
        v.rw = rw; v.mr = mr; v.ur = ur; v.alu = alu; v.rs = rs; v.rt = rt;
        v.fl = fl; v.hd = hd; v.data = data; v.ePc = ePc; v.eRw = eRw;
        v.eMr = eMr; v.eAlu = eAlu; v.eRs = eRs; v.eRt = eRt; v.eData = eData;
        v.eSc = eSc; v.eFc = eFc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        testsRun++;
        if (act !== want) begin
            testsFailed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    // Decode fields derived from a few vector fields so every EX output
    // has a predictable expected value
    task automatic driveId(input logic rw, input logic mr, input logic ur,
                           input logic [1:0] alu, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [31:0] data);
        bus.ID_RegWrite  = rw;
        bus.ID_MemRead   = mr;
        bus.ID_MemWrite  = 1'b0;
        bus.ID_MemtoReg  = mr;
        bus.ID_ALUSrc    = mr;
        bus.ID_RegDst    = rw & ~mr;
        bus.ID_ALUOp     = alu;
        bus.ID_UsesRt    = ur;
        bus.ID_ReadData1 = data;
        bus.ID_ReadData2 = data + 32'd1;
        bus.ID_Imm       = ~data;
        bus.ID_rs        = rs;
        bus.ID_rt        = rt;
        bus.ID_rd        = rt + 5'd1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Table: add; load-use pair; $zero; rt unused; flush vs stall;
        // 3-cycle hold; hold during hazard; then 5 load-use pairs.
        vecs[0]  = mk(1,0,1,2,  1, 2,0,0,32'h100, 1, 1,0,2,  1, 2,32'h100,0,0);
        vecs[1]  = mk(1,1,0,0,  4, 5,0,0,32'h101, 1, 1,1,0,  4, 5,32'h101,0,0);
        vecs[2]  = mk(1,0,1,2,  5, 7,0,0,32'h102, 0, 0,0,0,  5, 7,32'h102,1,0);
        vecs[3]  = mk(1,0,1,2,  5, 7,0,0,32'h103, 1, 1,0,2,  5, 7,32'h103,1,0);
        vecs[4]  = mk(1,1,0,0,  4, 0,0,0,32'h104, 1, 1,1,0,  4, 0,32'h104,1,0);
        vecs[5]  = mk(1,0,1,2,  0, 0,0,0,32'h105, 1, 1,0,2,  0, 0,32'h105,1,0);
        vecs[6]  = mk(1,1,0,0,  4, 5,0,0,32'h106, 1, 1,1,0,  4, 5,32'h106,1,0);
        vecs[7]  = mk(1,0,0,0,  9, 5,0,0,32'h107, 1, 1,0,0,  9, 5,32'h107,1,0);
        vecs[8]  = mk(1,1,0,0,  4, 5,0,0,32'h108, 1, 1,1,0,  4, 5,32'h108,1,0);
        vecs[9]  = mk(1,0,1,2,  5, 7,1,0,32'h109, 0, 0,0,0,  5, 7,32'h109,1,1);
        vecs[10] = mk(1,1,0,0, 10,11,0,1,32'h10A, 0, 0,0,0,  5, 7,32'h109,1,1);
        vecs[11] = mk(1,1,0,0, 12,13,0,1,32'h10B, 0, 0,0,0,  5, 7,32'h109,1,1);
        vecs[12] = mk(1,0,1,2, 14,15,0,1,32'h10C, 0, 0,0,0,  5, 7,32'h109,1,1);
        vecs[13] = mk(1,0,1,2, 20,21,0,0,32'h10D, 1, 1,0,2, 20,21,32'h10D,1,1);
        vecs[14] = mk(1,1,0,0,  4, 5,0,0,32'h10E, 1, 1,1,0,  4, 5,32'h10E,1,1);
        vecs[15] = mk(1,0,1,2,  1, 5,0,1,32'h10F, 0, 1,1,0,  4, 5,32'h10E,1,1);
        vecs[16] = mk(1,0,1,2,  1, 5,0,0,32'h110, 0, 0,0,0,  1, 5,32'h110,2,1);
        vecs[17] = mk(1,0,1,2,  1, 5,0,0,32'h111, 1, 1,0,2,  1, 5,32'h111,2,1);
        for (int k = 0; k < 5; k++) begin
            logic [31:0] dA, dB;
            dA = 32'h200 + 32'(2 * k);
            dB = dA + 32'd1;
            vecs[18 + 2*k] = mk(1,1,0,0, 4,5,0,0,dA, 1, 1,1,0, 4,5,dA, 2+k,1);
            vecs[19 + 2*k] = mk(1,0,1,2, 5,7,0,0,dB, 0, 0,0,0, 5,7,dB, 3+k,1);
        end

        // Reset for two cycles with a live instruction in ID
        reset_n = 1'b0; BranchFlush = 1'b0; Hold = 1'b0;
        driveId(1, 0, 1, 2, 3, 4, 32'hABCD);
        repeat (2) @(posedge clk);
        #1;
        check("reset EX_RegWrite", 32'(bus.EX_RegWrite), 0);
        check("reset EX_ALUOp", 32'(bus.EX_ALUOp), 0);
        check("reset EX_ReadData1", bus.EX_ReadData1, 0);
        check("reset EX_Imm", bus.EX_Imm, 0);
        check("reset EX_rs", 32'(bus.EX_rs), 0);
        check("reset EX_rd", 32'(bus.EX_rd), 0);
        check("reset StallCount", 32'(StallCount), 0);
        check("reset FlushCount", 32'(FlushCount), 0);
        check("reset PCWrite", 32'(PCWrite), 1);
        reset_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            vec_t v;
            int   smallSc;
            v = vecs[i];
            driveId(v.rw, v.mr, v.ur, v.alu, v.rs, v.rt, v.data);
            BranchFlush = v.fl;
            Hold        = v.hd;
            #1;
            check($sformatf("v%0d PCWrite", i), 32'(PCWrite), 32'(v.ePc));
            check($sformatf("v%0d IF_ID_Write", i), 32'(IF_ID_Write), 32'(v.ePc));
            @(posedge clk);
            #1;
            check($sformatf("v%0d EX_RegWrite", i), 32'(bus.EX_RegWrite), 32'(v.eRw));
            check($sformatf("v%0d EX_MemRead", i), 32'(bus.EX_MemRead), 32'(v.eMr));
            check($sformatf("v%0d EX_MemtoReg", i), 32'(bus.EX_MemtoReg), 32'(v.eMr));
            check($sformatf("v%0d EX_ALUSrc", i), 32'(bus.EX_ALUSrc), 32'(v.eMr));
            check($sformatf("v%0d EX_RegDst", i), 32'(bus.EX_RegDst), 32'(v.eRw & ~v.eMr));
            check($sformatf("v%0d EX_MemWrite", i), 32'(bus.EX_MemWrite), 0);
            check($sformatf("v%0d EX_ALUOp", i), 32'(bus.EX_ALUOp), 32'(v.eAlu));
            check($sformatf("v%0d EX_rs", i), 32'(bus.EX_rs), 32'(v.eRs));
            check($sformatf("v%0d EX_rt", i), 32'(bus.EX_rt), 32'(v.eRt));
            check($sformatf("v%0d EX_rd", i), 32'(bus.EX_rd), 32'(v.eRt + 5'd1));
            check($sformatf("v%0d EX_ReadData1", i), bus.EX_ReadData1, v.eData);
            check($sformatf("v%0d EX_ReadData2", i), bus.EX_ReadData2, v.eData + 32'd1);
            check($sformatf("v%0d EX_Imm", i), bus.EX_Imm, ~v.eData);
            check($sformatf("v%0d StallCount", i), 32'(StallCount), 32'(v.eSc));
            check($sformatf("v%0d FlushCount", i), 32'(FlushCount), 32'(v.eFc));
            smallSc = (v.eSc > 3) ? 3 : v.eSc;
            check($sformatf("v%0d small StallCount", i), 32'(smallStallCount), 32'(smallSc));
            check($sformatf("v%0d small FlushCount", i), 32'(smallFlushCount), 32'(v.eFc));
        end

        // Reset arriving mid-stall discards the bubble and releases the stall
        driveId(1, 1, 0, 0, 4, 5, 32'h300);
        BranchFlush = 1'b0; Hold = 1'b0;
        @(posedge clk);
        #1;
        check("midrst lw EX_MemRead", 32'(bus.EX_MemRead), 1);
        driveId(1, 0, 1, 2, 5, 7, 32'h301);
        #1;
        check("midrst hazard PCWrite", 32'(PCWrite), 0);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst EX_MemRead", 32'(bus.EX_MemRead), 0);
        check("midrst EX_rs", 32'(bus.EX_rs), 0);
        check("midrst StallCount", 32'(StallCount), 0);
        check("midrst small StallCount", 32'(smallStallCount), 0);
        check("midrst FlushCount", 32'(FlushCount), 0);
        check("midrst PCWrite released", 32'(PCWrite), 1);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("postrst EX_RegWrite", 32'(bus.EX_RegWrite), 1);
        check("postrst EX_rs", 32'(bus.EX_rs), 5);
        check("postrst EX_ReadData1", bus.EX_ReadData1, 32'h301);
        check("postrst StallCount", 32'(StallCount), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
